// File: rtl/bubble_launcher.sv
// bubble_launcher: preview-queue ball launcher with fixed-point flight and frame-synchronous outputs.
// Optional WALL_BOUNCE_EN reflects the ball off the side walls instead of reloading.
module bubble_launcher #(
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480,
    parameter int COLOR_W     = 2,
    parameter int QUEUE_DEPTH = 3,
    parameter int VEC_W       = 9,
    parameter int FRAC_W      = 4,
    parameter int START_X     = 320,
    parameter int START_Y     = 440
) (
    input  logic                           Clk,
    input  logic                           Reset,
    input  logic                           frame_clk,
    input  logic [COLOR_W-1:0]             random,
    input  logic [VEC_W-1:0]               x_vector,
    input  logic [VEC_W-1:0]               y_vector,
    input  logic                           fire,
    input  logic                           swap,
    input  logic                           inserted,
    input  logic                           game_active,
    output logic [9:0]                     ballX,
    output logic [9:0]                     ballY,
    output logic [COLOR_W-1:0]             ballColor,
    output logic                           ball_active,
    output logic [QUEUE_DEPTH*COLOR_W-1:0] queue_colors,
    output logic [15:0]                    shots
);
    localparam int PW = 11 + FRAC_W;
    localparam logic signed [PW-1:0] SX   = PW'(START_X << FRAC_W);
    localparam logic signed [PW-1:0] SY   = PW'(START_Y << FRAC_W);
    localparam logic signed [PW-1:0] XLIM = PW'(SCREEN_W << FRAC_W);
    localparam logic signed [PW-1:0] YLIM = PW'(SCREEN_H << FRAC_W);
`ifdef WALL_BOUNCE_EN
    localparam logic signed [PW-1:0] XMAX = PW'((SCREEN_W - 1) << FRAC_W);
`endif

    typedef enum logic [1:0] {IDLE, FLIGHT, RELOAD} state_t;

    state_t state, state_n;
    logic signed [PW-1:0] px, py, vx, vy, px_n, py_n, vx_n, vy_n, nx, ny;
    logic [COLOR_W-1:0] q [QUEUE_DEPTH];
    logic [COLOR_W-1:0] q_n [QUEUE_DEPTH];
    logic [15:0] shots_n;
    logic [2:0] d1, d2, rise;
    logic fire_rise, swap_rise, frame_rise, x_out, y_out;

    assign fire_rise  = rise[0];
    assign swap_rise  = rise[1];
    assign frame_rise = rise[2];
    assign nx    = px + vx;
    assign ny    = py + vy;
    assign x_out = nx[PW-1] || nx >= XLIM;
    assign y_out = ny[PW-1] || ny >= YLIM;

    for (genvar g = 0; g < QUEUE_DEPTH; g++) begin : g_flat
        assign queue_colors[g*COLOR_W +: COLOR_W] = q[g];
    end

    always_comb begin
        state_n = state;
        px_n    = px;
        py_n    = py;
        vx_n    = vx;
        vy_n    = vy;
        q_n     = q;
        shots_n = shots;
        case (state)
            IDLE: begin
                px_n = SX;
                py_n = SY;
                if (game_active && fire_rise) begin
                    state_n = FLIGHT;
                    vx_n    = {{(PW-VEC_W){x_vector[VEC_W-1]}}, x_vector};
                    vy_n    = {{(PW-VEC_W){y_vector[VEC_W-1]}}, y_vector};
                    shots_n = (shots == 16'hFFFF) ? shots : shots + 16'd1;
                end else if (game_active && swap_rise) begin
                    q_n[0] = q[1];
                    q_n[1] = q[0];
                end
            end
            FLIGHT: begin
                // inserted takes priority so an attached ball never advances past its cell
                if (inserted)
                    state_n = RELOAD;
                else if (frame_rise) begin
`ifdef WALL_BOUNCE_EN
                    if (y_out)
                        state_n = RELOAD;
                    else begin
                        px_n = x_out ? (nx[PW-1] ? '0 : XMAX) : nx;
                        vx_n = x_out ? -vx : vx;
                        py_n = ny;
                    end
`else
                    if (x_out || y_out)
                        state_n = RELOAD;
                    else begin
                        px_n = nx;
                        py_n = ny;
                    end
`endif
                end
            end
            RELOAD: begin
                for (int i = 0; i < QUEUE_DEPTH - 1; i++)
                    q_n[i] = q[i+1];
                q_n[QUEUE_DEPTH-1] = random;
                px_n    = SX;
                py_n    = SY;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            d1          <= '0;
            d2          <= '0;
            rise        <= '0;
            state       <= IDLE;
            px          <= SX;
            py          <= SY;
            vx          <= '0;
            vy          <= '0;
            shots       <= '0;
            for (int i = 0; i < QUEUE_DEPTH; i++)
                q[i] <= COLOR_W'(i);
            ballX       <= 10'(START_X);
            ballY       <= 10'(START_Y);
            ballColor   <= '0;
            ball_active <= 1'b0;
        end else begin
            d1    <= {frame_clk, swap, fire};
            d2    <= d1;
            rise  <= d1 & ~d2;
            state <= state_n;
            px    <= px_n;
            py    <= py_n;
            vx    <= vx_n;
            vy    <= vy_n;
            shots <= shots_n;
            q     <= q_n;
            if (frame_rise) begin
                ballX       <= px_n[FRAC_W +: 10];
                ballY       <= py_n[FRAC_W +: 10];
                ballColor   <= q_n[0];
                ball_active <= (state_n == FLIGHT);
            end
        end
    end
endmodule

// File: tb/tb_bubble_launcher.sv
// tb_bubble_launcher: directed scoreboard bench for bubble_launcher (default params).
// Bounce expectations follow WALL_BOUNCE_EN when it is defined for the build.
module tb_bubble_launcher;
    logic       Clk = 0, Reset = 1, frame_clk = 0, fire = 0, swap = 0, inserted = 0, game_active = 0;
    logic [1:0] random = 2'd3;
    logic [8:0] x_vector = '0, y_vector = '0;
    logic [9:0] ballX, ballY;
    logic [1:0] ballColor;
    logic       ball_active;
    logic [5:0] queue_colors;
    logic [15:0] shots;

    typedef struct {string tag; int val;} exp_t;
    exp_t sb[$];
    int total = 0, bad = 0, ms = 0, n;
    logic [1:0] mq [3] = '{2'd0, 2'd1, 2'd2};
    logic [1:0] t;

    always #5 Clk = ~Clk;

    bubble_launcher dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .random(random),
        .x_vector(x_vector), .y_vector(y_vector), .fire(fire), .swap(swap),
        .inserted(inserted), .game_active(game_active), .ballX(ballX), .ballY(ballY),
        .ballColor(ballColor), .ball_active(ball_active), .queue_colors(queue_colors),
        .shots(shots)
    );

    task automatic cyc(input int k);
        repeat (k) @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic frame();
        frame_clk = 1; cyc(4);
        frame_clk = 0; cyc(4);
    endtask

    task automatic want(input string tag, input int v);
        sb.push_back('{tag, v});
    endtask

    task automatic chk(input string tag, input logic [31:0] obs);
        exp_t e;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $error("FAIL %s: got %0d, scoreboard empty", tag, obs);
        end else begin
            e = sb.pop_front();
            assert (e.tag == tag && obs === 32'(e.val)) else begin
                bad++;
                $error("FAIL %s: got %0d want %0d (queued as %s)", tag, obs, e.val, e.tag);
            end
        end
    endtask

    function automatic int packq();
        return int'({mq[2], mq[1], mq[0]});
    endfunction

    function automatic void reload_model();
        mq[0] = mq[1];
        mq[1] = mq[2];
        mq[2] = random;
    endfunction

    initial begin
        cyc(3);
        Reset = 0;
        cyc(1);
        want("rst_x", 320);   chk("rst_x", 32'(ballX));
        want("rst_y", 440);   chk("rst_y", 32'(ballY));
        want("rst_q", 6'b10_01_00); chk("rst_q", 32'(queue_colors));
        want("rst_col", 0);   chk("rst_col", 32'(ballColor));
        want("rst_act", 0);   chk("rst_act", 32'(ball_active));
        want("rst_shots", 0); chk("rst_shots", 32'(shots));

        // straight-up shot at -2 px/frame
        game_active = 1; y_vector = 9'h1E0; x_vector = 0;
        ms++; want("shots1", ms);
        fire = 1; cyc(4); fire = 0; cyc(4);
        chk("shots1", 32'(shots));
        frame();
        want("y_f1", 438); chk("y_f1", 32'(ballY));
        want("act_f1", 1); chk("act_f1", 32'(ball_active));
        n = 1;
        while (ballY != 0 && n < 300) begin frame(); n++; end
        want("frames_to_top", 220); chk("frames_to_top", 32'(n));
        frame();
        want("act_exit", 0); chk("act_exit", 32'(ball_active));
        reload_model();
        want("q_reload", packq()); chk("q_reload", 32'(queue_colors));
        want("shots_after", ms);   chk("shots_after", 32'(shots));
        frame();
        want("y_home", 440);       chk("y_home", 32'(ballY));
        want("col_home", mq[0]);   chk("col_home", 32'(ballColor));

        // swap in IDLE, then swap/fire ignored in flight
        t = mq[0]; mq[0] = mq[1]; mq[1] = t;
        want("q_swap", packq());
        swap = 1; cyc(4); swap = 0; cyc(4);
        chk("q_swap", 32'(queue_colors));
        frame();
        want("col_swap", mq[0]); chk("col_swap", 32'(ballColor));
        ms++;
        fire = 1; cyc(4); fire = 0; cyc(4);
        swap = 1; cyc(4); swap = 0; cyc(4);
        fire = 1; cyc(4); fire = 0; cyc(4);
        want("q_flight_swap", packq()); chk("q_flight_swap", 32'(queue_colors));
        want("shots_flight", ms);       chk("shots_flight", 32'(shots));
        frame();
        want("y_f1b", 438); chk("y_f1b", 32'(ballY));

        // inserted aligned with the registered frame rise
        random = 2'd0;
        frame_clk = 1;
        @(posedge Clk); @(posedge Clk); #1 inserted = 1;
        @(posedge Clk); #1 inserted = 0;
        cyc(3); frame_clk = 0; cyc(4);
        want("y_ins", 438); chk("y_ins", 32'(ballY));
        want("act_ins", 0); chk("act_ins", 32'(ball_active));
        reload_model();
        want("q_ins", packq()); chk("q_ins", 32'(queue_colors));
        frame();
        want("y_ins_home", 440); chk("y_ins_home", 32'(ballY));

        // fire and swap together launch without swapping
        ms++;
        fire = 1; swap = 1; cyc(4); fire = 0; swap = 0; cyc(4);
        want("q_fs", packq()); chk("q_fs", 32'(queue_colors));
        want("shots_fs", ms);  chk("shots_fs", 32'(shots));
        frame();
        want("act_fs", 1); chk("act_fs", 32'(ball_active));
        random = 2'd1;
        inserted = 1; cyc(2); inserted = 0; cyc(2);
        reload_model();
        want("q_fs_rel", packq()); chk("q_fs_rel", 32'(queue_colors));

        // game inactive: fire ignored
        game_active = 0;
        fire = 1; cyc(4); fire = 0; cyc(4);
        frame();
        want("shots_inactive", ms); chk("shots_inactive", 32'(shots));
        want("act_inactive", 0);    chk("act_inactive", 32'(ball_active));

        // side wall at +10 px/frame
        game_active = 1; x_vector = 9'd160; y_vector = 0;
        ms++;
        fire = 1; cyc(4); fire = 0; cyc(4);
        repeat (31) frame();
        want("x_630", 630); chk("x_630", 32'(ballX));
        frame();
`ifdef WALL_BOUNCE_EN
        want("x_clamp", 639);   chk("x_clamp", 32'(ballX));
        want("act_clamp", 1);   chk("act_clamp", 32'(ball_active));
        frame();
        want("x_back", 629);    chk("x_back", 32'(ballX));
`else
        want("act_wall", 0);    chk("act_wall", 32'(ball_active));
        frame();
        want("x_wall_home", 320); chk("x_wall_home", 32'(ballX));
`endif
        want("shots_end", ms); chk("shots_end", 32'(shots));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
